lcd_write_arbiter: RTL and testbench

Shares the single-byte LCD character write port (write_en/data) among NREQ independent byte-stream requesters, such as the keyboard echo, CPU console and status messages. Arbitration is round-robin and at message granularity: a granted requester keeps the port until it sends a byte flagged last, or until it goes idle past a timeout. When ownership changes to a different requester, the block injects a carriage return (0x0D) so the display clears and the prompt is restored. It also paces writes with a minimum gap between write_en pulses.

---
 rtl/lcd_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin, message-granular sharing of one LCD byte write port
//   clock, reset       : clock and asynchronous active-high reset
//   i_req_valid/last   : per-requester byte valid and end-of-message flag
//   i_req_data         : requester i byte on [8i+7:8i]
//   o_req_ready        : byte accepted when valid && ready (owner only, STREAM only)
//   o_write_en/o_data  : one-cycle LCD write strobe and its byte
//   o_grant/o_owner_id : one-hot current owner / index of current or most recent owner
//   o_busy             : high whenever the arbiter is not idle
//   o_timeout_evt      : one-cycle pulse on forced release of a silent owner
module lcd_write_arbiter #(
    parameter int NREQ         = 3,
    parameter int MIN_GAP      = 2,
    parameter int TIMEOUT      = 1024,
    parameter int CR_ON_SWITCH = 1,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [8*NREQ-1:0] i_req_data,
    input  logic [NREQ-1:0]   i_req_last,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_write_en,
    output logic [7:0]        o_data,
    output logic [NREQ-1:0]   o_grant,
    output logic [IW-1:0]     o_owner_id,
    output logic              o_busy,
    output logic              o_timeout_evt
);
    typedef enum logic [1:0] {IDLE, PREFIX, STREAM, GAP} state_t;
    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_owner_id, r_rr_ptr, r_last_owner;
    logic            r_last_valid, r_release, r_write_en, r_busy, r_timeout_evt;
    logic [7:0]      r_data;
    logic [3:0]      r_gap_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            w_any, w_own_valid, w_own_last;
    logic [IW-1:0]   w_winner, w_next_ptr;
    logic [7:0]      w_own_data;
    assign w_own_valid   = i_req_valid[r_owner_id];
    assign w_own_last    = i_req_last[r_owner_id];
    assign w_own_data    = i_req_data[{r_owner_id, 3'b000} +: 8];
    assign w_next_ptr    = (int'(r_owner_id) == NREQ - 1) ? '0 : r_owner_id + IW'(1);
    assign o_req_ready   = (r_state == STREAM) ? r_grant : '0;
    assign o_write_en    = r_write_en;
    assign o_data        = r_data;
    assign o_grant       = r_grant;
    assign o_owner_id    = r_owner_id;
    assign o_busy        = r_busy;
    assign o_timeout_evt = r_timeout_evt;
    // Scan downward so the last hit is the nearest set bit at or after rr_ptr.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_any    = 1'b1;
                w_winner = IW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_owner_id    <= '0;
            r_rr_ptr      <= '0;
            r_last_owner  <= '0;
            r_last_valid  <= 1'b0;
            r_release     <= 1'b0;
            r_write_en    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_data        <= 8'h00;
            r_gap_cnt     <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_write_en    <= 1'b0;
            r_timeout_evt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= NREQ'(1) << w_winner;
                        r_owner_id <= w_winner;
                        r_busy     <= 1'b1;
                        r_release  <= 1'b0;
                        r_to_cnt   <= '0;
                        r_state    <= (CR_ON_SWITCH != 0 && (!r_last_valid || w_winner != r_last_owner))
                                      ? PREFIX : STREAM;
                    end
                end
                PREFIX: begin
                    r_write_en   <= 1'b1;
                    r_data       <= 8'h0D;
                    r_last_owner <= r_owner_id;
                    r_last_valid <= 1'b1;
                    r_gap_cnt    <= 4'(MIN_GAP);
                    r_state      <= (MIN_GAP == 0) ? STREAM : GAP;
                end
                STREAM: begin
                    if (w_own_valid) begin
                        r_to_cnt   <= '0;
                        r_write_en <= 1'b1;
                        r_data     <= w_own_data;
                        if (MIN_GAP != 0) begin
                            r_gap_cnt <= 4'(MIN_GAP);
                            r_release <= w_own_last;
                            r_state   <= GAP;
                        end else if (w_own_last) begin
                            r_grant  <= '0;
                            r_busy   <= 1'b0;
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= IDLE;
                        end
                    end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                        // Silent owner: release without emitting anything; last_owner is kept.
                        r_timeout_evt <= 1'b1;
                        r_grant       <= '0;
                        r_busy        <= 1'b0;
                        r_rr_ptr      <= w_next_ptr;
                        r_state       <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                GAP: begin
                    // Entered on the strobe cycle, so MIN_GAP further cycles pass before ready returns.
                    if (r_gap_cnt != 4'd0) begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end else if (r_release) begin
                        r_release <= 1'b0;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_rr_ptr  <= w_next_ptr;
                        r_state   <= IDLE;
                    end else begin
                        r_state <= STREAM;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed checks of arbitration, CR prefix, pacing, timeout and reset
//   u=0: MIN_GAP=2, TIMEOUT=1024, CR on; u=1: MIN_GAP=2, TIMEOUT=8, CR on; u=2: MIN_GAP=0, CR off
module tb_lcd_write_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  v [3];
    logic [2:0]  l [3];
    logic [23:0] d [3];
    logic [2:0]  rdy [3];
    logic [2:0]  gnt [3];
    logic [1:0]  oid [3];
    logic [7:0]  dat [3];
    logic        we [3];
    logic        bsy [3];
    logic        tev [3];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clock = ~clock;

    lcd_write_arbiter #(.NREQ(3), .MIN_GAP(2), .TIMEOUT(1024), .CR_ON_SWITCH(1)) u_a (
        .clock(clock), .reset(reset), .i_req_valid(v[0]), .i_req_data(d[0]), .i_req_last(l[0]),
        .o_req_ready(rdy[0]), .o_write_en(we[0]), .o_data(dat[0]), .o_grant(gnt[0]),
        .o_owner_id(oid[0]), .o_busy(bsy[0]), .o_timeout_evt(tev[0]));
    lcd_write_arbiter #(.NREQ(3), .MIN_GAP(2), .TIMEOUT(8), .CR_ON_SWITCH(1)) u_b (
        .clock(clock), .reset(reset), .i_req_valid(v[1]), .i_req_data(d[1]), .i_req_last(l[1]),
        .o_req_ready(rdy[1]), .o_write_en(we[1]), .o_data(dat[1]), .o_grant(gnt[1]),
        .o_owner_id(oid[1]), .o_busy(bsy[1]), .o_timeout_evt(tev[1]));
    lcd_write_arbiter #(.NREQ(3), .MIN_GAP(0), .TIMEOUT(1024), .CR_ON_SWITCH(0)) u_c (
        .clock(clock), .reset(reset), .i_req_valid(v[2]), .i_req_data(d[2]), .i_req_last(l[2]),
        .o_req_ready(rdy[2]), .o_write_en(we[2]), .o_data(dat[2]), .o_grant(gnt[2]),
        .o_owner_id(oid[2]), .o_busy(bsy[2]), .o_timeout_evt(tev[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance until unit u strobes (bounded); n is the number of edges taken.
    task automatic wait_we(input int u, output int n, output logic [7:0] b);
        n = 0;
        do begin
            tick();
            n++;
        end while (!we[u] && n < 40);
        b = dat[u];
    endtask

    initial begin
        int         n;
        int         cnt;
        logic [7:0] b;
        logic [7:0] msg [4];
        msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33; msg[3] = 8'h34;
        for (int i = 0; i < 3; i++) begin
            v[i] = '0; l[i] = '0; d[i] = '0;
        end
        tick(); tick();
        chk("rst_we", 32'(we[0]), 0);
        chk("rst_data", 32'(dat[0]), 0);
        chk("rst_grant", 32'(gnt[0]), 0);
        chk("rst_busy_oid", {30'(bsy[0]), oid[0]}, 0);
        chk("rst_ready_tevt", {28'(rdy[0]), tev[0]}, 0);
        reset = 1'b0;
        tick();
        // Test 1: requester 0 sends "HI"
        v[0] = 3'b001; d[0][7:0] = 8'h48;
        tick();
        chk("t1_grant", 32'(gnt[0]), 32'b001);
        chk("t1_busy", 32'(bsy[0]), 1);
        tick();
        chk("t1_cr", {24'(we[0]), dat[0]}, 32'h1_0D);
        tick();
        chk("t1_gap1_ready", {28'(rdy[0]), we[0]}, 0);
        tick();
        chk("t1_gap2_ready", {28'(rdy[0]), we[0]}, 0);
        tick();
        chk("t1_stream_ready", 32'(rdy[0]), 32'b001);
        tick();
        chk("t1_H", {24'(we[0]), dat[0]}, 32'h1_48);
        d[0][7:0] = 8'h49; l[0] = 3'b001;
        wait_we(0, n, b);
        chk("t1_I_spacing", n, 4);
        chk("t1_I", b, 8'h49);
        chk("t1_grant_hold", 32'(gnt[0]), 32'b001);
        v[0] = 3'b000;
        tick(); tick();
        chk("t1_grant_gap_end", 32'(gnt[0]), 32'b001);
        tick();
        chk("t1_release", {28'(gnt[0]), bsy[0]}, 0);
        // Test 2: same owner again, no CR
        v[0] = 3'b001; d[0][7:0] = 8'h41;
        wait_we(0, n, b);
        chk("t2_latency", n, 2);
        chk("t2_A_no_cr", b, 8'h41);
        v[0] = 3'b000;
        tick(); tick(); tick();
        chk("t2_idle", 32'(bsy[0]), 0);
        // Test 3: requesters 0 and 2 contend with rr_ptr=1
        v[0] = 3'b101; d[0] = {8'h43, 8'h00, 8'h42}; l[0] = 3'b101;
        tick();
        chk("t3_grant2", {30'(gnt[0]), oid[0]}, {30'b100, 2'd2});
        wait_we(0, n, b);
        chk("t3_cr2", {8'(n), 16'h0, b}, {8'd1, 16'h0, 8'h0D});
        wait_we(0, n, b);
        chk("t3_C", {8'(n), 16'h0, b}, {8'd4, 16'h0, 8'h43});
        v[0] = 3'b001;
        tick(); tick(); tick();
        chk("t3_idle_between", {28'(gnt[0]), bsy[0]}, 0);
        tick();
        chk("t3_grant0", {30'(gnt[0]), oid[0]}, {30'b001, 2'd0});
        tick();
        chk("t3_cr0", {24'(we[0]), dat[0]}, 32'h1_0D);
        wait_we(0, n, b);
        chk("t3_B", {8'(n), 16'h0, b}, {8'd4, 16'h0, 8'h42});
        v[0] = 3'b000;
        tick(); tick(); tick();
        // Test 4: timeout with TIMEOUT=8
        v[1] = 3'b010; d[1][15:8] = 8'h58;
        wait_we(1, n, b);
        chk("t4_cr", {8'(n), 16'h0, b}, {8'd2, 16'h0, 8'h0D});
        chk("t4_grant1", 32'(gnt[1]), 32'b010);
        wait_we(1, n, b);
        chk("t4_X", {8'(n), 16'h0, b}, {8'd4, 16'h0, 8'h58});
        v[1] = 3'b000;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(tev[1]) + int'(we[1]);
        end
        chk("t4_no_early_evt", cnt, 0);
        chk("t4_still_owned", 32'(gnt[1]), 32'b010);
        tick();
        chk("t4_evt", {28'(gnt[1]), bsy[1], tev[1]}, 32'b1);
        tick();
        chk("t4_evt_once", {24'(tev[1]), we[1]}, 0);
        // Test 6: MIN_GAP=0, CR off, 4 back-to-back bytes
        v[2] = 3'b010; d[2][15:8] = msg[0];
        tick();
        chk("t6_grant_ready", {28'(rdy[2]), we[2]}, {28'b010, 1'b0});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t6_byte%0d", i), {24'(we[2]), dat[2]}, {24'd1, msg[i]});
            if (i < 3) begin
                d[2][15:8] = msg[i + 1];
                l[2] = (i == 2) ? 3'b010 : 3'b000;
            end
        end
        chk("t6_released", 32'(gnt[2]), 0);
        v[2] = 3'b000;
        tick();
        chk("t6_quiet", 32'(we[2]), 0);
        // Test 5: reset between accept and strobe on unit 0
        v[0] = 3'b010; d[0][15:8] = 8'h5A; l[0] = 3'b010;
        wait_we(0, n, b);
        chk("t5_cr", b, 8'h0D);
        tick(); tick(); tick();
        chk("t5_accept_cycle", 32'(rdy[0]), 32'b010);
        reset = 1'b1;
        #1;
        chk("t5_async_clear", {20'(dat[0]), we[0], gnt[0], bsy[0], oid[0]}, 0);
        chk("t5_async_ready", 32'(rdy[0]), 0);
        tick();
        chk("t5_no_strobe", 32'(we[0]), 0);
        reset = 1'b0;
        wait_we(0, n, b);
        chk("t5_cr_after_reset", {8'(n), 16'h0, b}, {8'd2, 16'h0, 8'h0D});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
